lutram_march_ctrl: RTL



---
 rtl/lutram_march_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/lutram_march_ctrl.sv
// March C- self-test sequencer for a single-port, async-read distributed RAM.
// Define LUTRAM_MARCH_STOP_ON_FAIL_EN to halt at the first mismatch instead of running the full sequence.
module lutram_march_ctrl #(
    parameter int A_WIDTH   = 6,
    parameter int ERR_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    output logic [A_WIDTH-1:0]   ram_a_o,
    output logic                 ram_d_o,
    output logic                 ram_we_o,
    input  logic                 ram_q_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [A_WIDTH-1:0]   fail_addr_o,
    output logic [2:0]           fail_elem_o,
    output logic [ERR_WIDTH-1:0] err_count_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DONE
    } state_t;

    localparam logic [A_WIDTH-1:0]   ADDR_FIRST = '0;
    localparam logic [A_WIDTH-1:0]   ADDR_LAST  = {A_WIDTH{1'b1}};
    localparam logic [A_WIDTH-1:0]   ADDR_ONE   = A_WIDTH'(1);
    localparam logic [ERR_WIDTH-1:0] ERR_ONE    = ERR_WIDTH'(1);

    state_t                 state_q, state_d;
    logic                   phase_wr_q, phase_wr_d;
    logic [A_WIDTH-1:0]     addr_q, addr_d;
    logic                   we_q, we_d;
    logic                   wd_q, wd_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic [A_WIDTH-1:0]     fail_addr_q, fail_addr_d;
    logic [2:0]             fail_elem_q, fail_elem_d;
    logic [ERR_WIDTH-1:0]   err_q, err_d;
    logic                   is_read;
    logic                   mismatch;
    logic                   terminal;
    logic [A_WIDTH-1:0]     step_addr;

    function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] c);
        if (&c) return c;
        return c + ERR_ONE;
    endfunction

    function automatic logic [2:0] elem_idx(input state_t s);
        case (s)
            S_M1:    return 3'd1;
            S_M2:    return 3'd2;
            S_M3:    return 3'd3;
            S_M4:    return 3'd4;
            S_M5:    return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic is_rw_elem(input state_t s);
        return (s == S_M1) || (s == S_M2) || (s == S_M3) || (s == S_M4);
    endfunction

    function automatic logic is_down(input state_t s);
        return (s == S_M3) || (s == S_M4);
    endfunction

    // Value written by the element; M0, M2 and M4 write 0.
    function automatic logic wr_val(input state_t s);
        return (s == S_M1) || (s == S_M3);
    endfunction

    // Value a read expects; M1, M3 and M5 read back 0.
    function automatic logic rd_exp(input state_t s);
        return (s == S_M2) || (s == S_M4);
    endfunction

    function automatic state_t next_elem(input state_t s);
        case (s)
            S_M1:    return S_M2;
            S_M2:    return S_M3;
            S_M3:    return S_M4;
            S_M4:    return S_M5;
            default: return S_DONE;
        endcase
    endfunction

    always_comb begin
        is_read   = (is_rw_elem(state_q) && !phase_wr_q) || (state_q == S_M5);
        mismatch  = is_read && (ram_q_i != rd_exp(state_q));
        terminal  = is_down(state_q) ? (addr_q == ADDR_FIRST) : (addr_q == ADDR_LAST);
        step_addr = is_down(state_q) ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
    end

    always_comb begin
        state_d     = state_q;
        phase_wr_d  = phase_wr_q;
        addr_d      = addr_q;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        pass_d      = pass_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d     = S_M0;
                    phase_wr_d  = 1'b0;
                    addr_d      = ADDR_FIRST;
                    err_d       = '0;
                    fail_addr_d = '0;
                    fail_elem_d = '0;
                    pass_d      = 1'b0;
                end
            end
            S_M0: begin
                if (terminal) begin
                    state_d    = S_M1;
                    phase_wr_d = 1'b0;
                    addr_d     = ADDR_FIRST;
                end else begin
                    addr_d = step_addr;
                end
            end
            S_M1, S_M2, S_M3, S_M4: begin
                if (!phase_wr_q) begin
                    phase_wr_d = 1'b1;
                end else begin
                    phase_wr_d = 1'b0;
                    if (terminal) begin
                        state_d = next_elem(state_q);
                        addr_d  = is_down(state_d) ? ADDR_LAST : ADDR_FIRST;
                    end else begin
                        addr_d = step_addr;
                    end
                end
            end
            S_M5: begin
                if (terminal) state_d = S_DONE;
                else          addr_d  = step_addr;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (mismatch) begin
            err_d = sat_inc(err_q);
            if (err_q == '0) begin
                fail_addr_d = addr_q;
                fail_elem_d = elem_idx(state_q);
            end
`ifdef LUTRAM_MARCH_STOP_ON_FAIL_EN
            state_d    = S_DONE;
            phase_wr_d = 1'b0;
            addr_d     = addr_q;
`endif
        end

        if (state_d == S_DONE) pass_d = (err_d == '0);

        // RAM controls are registered from the next state so they line up with addr_q.
        we_d   = (state_d == S_M0) || (is_rw_elem(state_d) && phase_wr_d);
        wd_d   = we_d && wr_val(state_d);
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            phase_wr_q  <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wd_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            phase_wr_q  <= phase_wr_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wd_q        <= wd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            err_q       <= err_d;
        end
    end

    assign ram_a_o     = addr_q;
    assign ram_d_o     = wd_q;
    assign ram_we_o    = we_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_elem_o = fail_elem_q;
    assign err_count_o = err_q;

endmodule
